// File: rtl/display_varredura.sv
// Four-digit 7-segment scan controller with guard blanking between slots.
// Optional per-digit blink compiled in with `define DISPLAY_PISCA_EN.
module display_varredura #(
  parameter int DIV          = 50000,
  parameter int GUARD        = 500,
  parameter int BLINK_FRAMES = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [6:0] seg_d0,
  input  logic [6:0] seg_d1,
  input  logic [6:0] seg_d2,
  input  logic [6:0] seg_d3,
  input  logic [3:0] pisca,
  output logic [6:0] seg,
  output logic [3:0] an_n,
  output logic [1:0] slot,
  output logic       frame
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          slot_end;
  logic          wrap;
  logic          guard_win;
  logic          mask;
  logic          blank;
  logic [6:0]    seg_sel;

  always_comb begin
    slot_end  = en && (cnt == CNT_LAST);
    wrap      = slot_end && (idx == 2'd3);
    guard_win = (GUARD != 0) && (cnt < GUARD_C);
    blank     = !en || guard_win || mask;
    case (idx)
      2'd0:    seg_sel = seg_d0;
      2'd1:    seg_sel = seg_d1;
      2'd2:    seg_sel = seg_d2;
      default: seg_sel = seg_d3;
    endcase
  end

  // Prescaler and digit index only move while enabled; en=0 freezes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (en) begin
      if (slot_end) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef DISPLAY_PISCA_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] bcnt;
  logic          ph;

  // Blink phase flips every BLINK_FRAMES full frames, on the frame wrap edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt <= '0;
      ph   <= 1'b0;
    end else if (wrap) begin
      if (bcnt == BCNT_LAST) begin
        bcnt <= '0;
        ph   <= ~ph;
      end else begin
        bcnt <= bcnt + BW'(1);
      end
    end
  end

  always_comb mask = pisca[idx] && ph;
`else
  logic unused_pisca;

  always_comb begin
    mask         = 1'b0;
    unused_pisca = ^pisca;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg   <= 7'h7F;
      an_n  <= 4'hF;
      frame <= 1'b0;
    end else begin
      seg   <= blank ? 7'h7F : seg_sel;
      an_n  <= blank ? 4'hF : ~(4'b0001 << idx);
      frame <= wrap;
    end
  end

  assign slot = idx;

endmodule

// File: tb/tb_display_varredura.sv
// Bench for display_varredura: random stimulus against a time-based reference
// model (position derived from the count of enabled cycles since reset).
module tb_display_varredura;

  localparam int DIV = 8;
  localparam int GUARD = 2;
  localparam int BF = 2;
`ifdef DISPLAY_PISCA_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [6:0] seg_d0, seg_d1, seg_d2, seg_d3;
  logic [3:0] pisca;
  logic [6:0] seg;
  logic [3:0] an_n;
  logic [1:0] slot;
  logic       frame;

  display_varredura #(.DIV(DIV), .GUARD(GUARD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .seg_d0(seg_d0), .seg_d1(seg_d1), .seg_d2(seg_d2), .seg_d3(seg_d3),
    .pisca(pisca), .seg(seg), .an_n(an_n), .slot(slot), .frame(frame)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t = 0;  // enabled cycles since reset release
  logic [6:0] exp_seg;
  logic [3:0] exp_an;
  logic [1:0] exp_slot;
  logic       exp_frame;

  // Predicts the outputs after the coming edge, then advances one clock.
  task automatic tick();
    int s, p, fr;
    bit phm, blank;
    logic [6:0] sd;
    p = t % DIV;
    s = (t / DIV) % 4;
    fr = t / (4 * DIV);
    phm = ((fr / BF) % 2) == 1;
    blank = !en || (p < GUARD) || (BLINK_ON && pisca[s] && phm);
    case (s)
      0: sd = seg_d0;
      1: sd = seg_d1;
      2: sd = seg_d2;
      default: sd = seg_d3;
    endcase
    exp_seg = blank ? 7'h7F : sd;
    exp_an = blank ? 4'hF : ~(4'b0001 << s);
    exp_frame = en && ((t % (4 * DIV)) == (4 * DIV - 1));
    @(posedge clk);
    #1;
    cyc++;
    if (en) t++;
    exp_slot = 2'((t / DIV) % 4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; pisca = 4'h0;
    seg_d0 = 7'h40; seg_d1 = 7'h79; seg_d2 = 7'h24; seg_d3 = 7'h30;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({seg, an_n, slot, frame} !== {7'h7F, 4'hF, 2'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_hold: seg=%h an_n=%b slot=%0d frame=%b, want 7f 1111 0 0", seg, an_n, slot, frame);
    end
    rst_n = 1'b1; t = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({seg, an_n, slot, frame} !== {exp_seg, exp_an, exp_slot, exp_frame}) begin
        n_bad++;
        $display("FAIL reset_release cyc %0d: seg=%h an_n=%b slot=%0d frame=%b, want %h %b %0d %b",
                 cyc, seg, an_n, slot, frame, exp_seg, exp_an, exp_slot, exp_frame);
      end
    end
    n_cmp++;
    if (an_n !== 4'b1110 || seg !== 7'h40) begin
      n_bad++;
      $display("FAIL first_lit: an_n=%b seg=%h, want 1110 40", an_n, seg);
    end
  endtask

  task automatic test_scan_order();
    int frames = 0;
    for (int i = 0; i < 4 * DIV - 3; i++) begin
      tick();
      if (frame === 1'b1) frames++;
      n_cmp++;
      if ({seg, an_n, slot, frame} !== {exp_seg, exp_an, exp_slot, exp_frame}) begin
        n_bad++;
        $display("FAIL scan_order cyc %0d: seg=%h an_n=%b slot=%0d frame=%b, want %h %b %0d %b",
                 cyc, seg, an_n, slot, frame, exp_seg, exp_an, exp_slot, exp_frame);
      end
    end
    n_cmp++;
    if (frames != 1) begin
      n_bad++;
      $display("FAIL frame_count: got %0d pulses, want 1", frames);
    end
  endtask

  task automatic test_enable_freeze();
    for (int i = 0; i < 64 && !(((t / DIV) % 4) == 1 && (t % DIV) == 4); i++) tick();
    en = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i == 10) en = 1'b1;
      tick();
      n_cmp++;
      if ({seg, an_n, slot, frame} !== {exp_seg, exp_an, exp_slot, exp_frame}) begin
        n_bad++;
        $display("FAIL enable_freeze cyc %0d: seg=%h an_n=%b slot=%0d frame=%b, want %h %b %0d %b",
                 cyc, seg, an_n, slot, frame, exp_seg, exp_an, exp_slot, exp_frame);
      end
    end
  endtask

  task automatic test_live_input();
    for (int i = 0; i < 64 && !(((t / DIV) % 4) == 2 && (t % DIV) == 4); i++) tick();
    tick();
    seg_d2 = 7'h12;
    tick();
    n_cmp++;
    if (seg !== 7'h12 || an_n !== 4'b1011) begin
      n_bad++;
      $display("FAIL live_input: seg=%h an_n=%b, want 12 1011", seg, an_n);
    end
    for (int i = 0; i < 2 * DIV; i++) begin
      if (i % 3 == 0) seg_d2 = 7'($urandom_range(0, 127));
      tick();
      n_cmp++;
      if ({seg, an_n, slot, frame} !== {exp_seg, exp_an, exp_slot, exp_frame}) begin
        n_bad++;
        $display("FAIL live_model cyc %0d: seg=%h an_n=%b slot=%0d frame=%b, want %h %b %0d %b",
                 cyc, seg, an_n, slot, frame, exp_seg, exp_an, exp_slot, exp_frame);
      end
    end
    seg_d2 = 7'h24;
  endtask

  task automatic test_blink(input logic [3:0] req);
    pisca = req;
    for (int i = 0; i < 6 * 4 * DIV; i++) begin
      tick();
      n_cmp++;
      if ({seg, an_n, slot, frame} !== {exp_seg, exp_an, exp_slot, exp_frame}) begin
        n_bad++;
        $display("FAIL blink_%b cyc %0d: seg=%h an_n=%b slot=%0d frame=%b, want %h %b %0d %b",
                 req, cyc, seg, an_n, slot, frame, exp_seg, exp_an, exp_slot, exp_frame);
      end
    end
    pisca = 4'h0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 64 && !(((t / DIV) % 4) == 2 && (t % DIV) == 5); i++) tick();
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({seg, an_n, slot, frame} !== {7'h7F, 4'hF, 2'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid: seg=%h an_n=%b slot=%0d frame=%b, want 7f 1111 0 0", seg, an_n, slot, frame);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1; t = 0;
    for (int i = 0; i < 2 * DIV; i++) begin
      tick();
      n_cmp++;
      if ({seg, an_n, slot, frame} !== {exp_seg, exp_an, exp_slot, exp_frame}) begin
        n_bad++;
        $display("FAIL reset_restart cyc %0d: seg=%h an_n=%b slot=%0d frame=%b, want %h %b %0d %b",
                 cyc, seg, an_n, slot, frame, exp_seg, exp_an, exp_slot, exp_frame);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) seg_d0 = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) seg_d1 = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) seg_d3 = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 63) == 0) pisca = 4'($urandom_range(0, 15));
      tick();
      n_cmp++;
      if ({seg, an_n, slot, frame} !== {exp_seg, exp_an, exp_slot, exp_frame}) begin
        n_bad++;
        $display("FAIL random cyc %0d: seg=%h an_n=%b slot=%0d frame=%b, want %h %b %0d %b",
                 cyc, seg, an_n, slot, frame, exp_seg, exp_an, exp_slot, exp_frame);
      end
    end
    en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_enable_freeze();
    test_live_input();
    test_blink(4'b0001);
    test_blink(4'hF);
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/display_varredura.md
# display_varredura

Time-multiplexed scan controller for the four-digit 7-segment display. Takes four active-low segment patterns (one per digit, e.g. the speed digit from the speed decoder and the mode/direction digits from their decoders) and drives a shared segment bus plus active-low digit enables. A programmable guard interval blanks the display between digit slots to suppress ghosting. An optional per-digit blink masks selected digits on a slow frame-based cadence.

## Interface
- DIV, 50000: clock cycles per digit slot; legal range is GUARD+1 or more.
- GUARD, 500: blank cycles at the start of every slot; 0 disables the guard.
- BLINK_FRAMES, 50: full frames (4 slots each) per blink half-period; minimum 1.
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  scan enable; low freezes the scan and blanks the display
- seg_d0, seg_d1, seg_d2, seg_d3  input  7 each  active-low pattern per digit; bit0 = a … bit6 = g
- pisca  input  4  per-digit blink request; bit i is for digit i
- seg  output  7  active-low segment bus; bit0 = a … bit6 = g
- an_n  output  4  active-low digit enables; at most one bit low
- slot  output  2  index of the digit currently scanned
- frame  output  1  one-cycle pulse when slot wraps from 3 to 0

## Operation
- State:
  - prescaler cnt, 0..DIV-1;
  - digit index idx, 0..3;
  - blink frame counter bcnt, 0..BLINK_FRAMES-1;
  - blink phase ph.
- Advance when en=1:
  - cnt increments each cycle.
  - At cnt==DIV-1, cnt becomes 0 and idx increments modulo 4 (3 wraps to 0).
  - On the 3→0 wrap, frame pulses and bcnt advances.
  - At bcnt==BLINK_FRAMES-1 with a wrap, bcnt becomes 0 and ph toggles.
- Window per slot:
  - Guard window is cnt < GUARD.
  - Active window is cnt >= GUARD.
- Output rule, evaluated from current state and inputs and registered on the next edge:
  - Blank (seg=7'h7F, an_n=4'hF) when any of the following holds: en=0; guard window; blink mask active for idx.
  - Otherwise an_n has only bit idx low, and seg equals seg_d[idx] unmodified.
- en=0: cnt, idx, bcnt and ph hold their values. When en returns to 1, counting resumes from the held values.
- Segment inputs are not latched per slot. A change to seg_d[idx] during the active window appears on seg one cycle later.
- slot mirrors idx combinationally from the register. frame is registered.
- Reset mid-operation (rst_n low at any time):
  - All state and outputs go to their reset values immediately.
  - After release, the scan restarts at digit 0, cnt=0, ph=0.

## Timing
- Reset values: seg=7'h7F, an_n=4'hF, slot=0, frame=0, cnt=0, idx=0, bcnt=0, ph=0.
- Output latency: one cycle from state/inputs to seg and an_n.
- First edge after reset release with en=1:
  - Outputs reflect cnt=0, which is the guard window, so the display is blank.
  - Digit 0 first lights GUARD+1 cycles after release.
- Slot length is exactly DIV cycles. Each slot is GUARD blank cycles followed by DIV-GUARD lit cycles.
- Full frame is 4·DIV cycles. A blink half-period is BLINK_FRAMES·4·DIV cycles.
- frame is high for exactly one cycle. It appears on the edge following the cycle in which idx wraps 3→0 (registered).
- Simultaneous events:
  - The slot wrap and bcnt/ph update occur on the same edge.
  - Deasserting en on a wrap edge suppresses that wrap.

## Configuration
- DISPLAY_PISCA_EN defined: blink mask active means pisca[idx]=1 and ph=1. The bcnt and ph logic is compiled in.
- DISPLAY_PISCA_EN undefined:
  - The pisca port is still present but ignored.
  - The bcnt and ph logic is removed.
  - The blink mask is never active.

## Test plan
Parameters for all scenarios: DIV=8, GUARD=2, BLINK_FRAMES=2; seg_d0..3 = 7'h40, 7'h79, 7'h24, 7'h30.

1. Reset: rst_n=0 mid-slot with idx=2 → seg=7'h7F, an_n=4'hF, slot=0 immediately. After release, the first lit output is an_n=4'b1110, seg=7'h40, on the 3rd edge.
2. Scan order: en=1 for 32 cycles → each slot shows 2 cycles blank then 6 cycles lit. an_n sequence is 1110, 1101, 1011, 0111. frame pulses once, at the 3→0 wrap.
3. Enable freeze: drop en during digit 1's active window → next edge blank. Hold en=0 for 10 cycles, then raise it → digit 1 resumes for its remaining lit cycles.
4. Live input change: change seg_d2 from 7'h24 to 7'h12 mid-active-window of digit 2 → seg shows 7'h12 one cycle later, with an_n unchanged.
5. Blink (macro defined): pisca=4'b0001 → digit 0 is lit during frames 0–1, blank during frames 2–3, lit during frames 4–5. Other digits are unaffected.
6. Blink (macro undefined): pisca=4'hF → all digits are lit every frame, identical to pisca=0.
